// File: rtl/tone_sequencer.sv
// Step-table tone player: each table entry gives a duration in unit ticks and a
// square-wave half-period. Optional TONE_SEQUENCER_LOOP_EN makes playback repeat.
module tone_sequencer #(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned DUR_W    = 4,
   parameter int unsigned HALF_W   = 21,
   parameter int unsigned TICK_DIV = 6_250_000,
   parameter int unsigned TICK_W   = 23
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iSTART,
   input  logic              iSTOP,
   input  logic              iWE,
   input  logic [ADDR_W-1:0] iWADDR,
   input  logic [DUR_W-1:0]  iWDUR,
   input  logic [HALF_W-1:0] iWHALF,
   output logic              oSOUND,
   output logic              oBUSY,
   output logic [ADDR_W-1:0] oSTEP,
   output logic              oDONE
);
   localparam int unsigned STEPS = 2 ** ADDR_W;

   typedef enum logic {IDLE, PLAY} state_t;

   state_t            state, stateNxt;
   logic [DUR_W-1:0]  durTab  [STEPS];
   logic [HALF_W-1:0] halfTab [STEPS];
   logic [TICK_W-1:0] tickCnt, tickNxt;
   logic [DUR_W-1:0]  durCnt, durNxt;
   logic [HALF_W-1:0] halfCnt, halfNxt;
   logic [ADDR_W-1:0] stepR, stepNxt;
   logic              sound, soundNxt;
   logic              done, doneNxt;

   logic [DUR_W-1:0]  curDur, nextDur;
   logic [HALF_W-1:0] curHalf;
   logic              tickWrap, stepDone, lastStep, emptyEntry, seqEnd, halfWrap;

   assign curDur   = durTab[stepR];
   assign curHalf  = halfTab[stepR];
   assign nextDur  = durTab[stepR + ADDR_W'(1)];
   assign lastStep = &stepR;
   assign tickWrap = (tickCnt == TICK_W'(TICK_DIV - 1));
   // Compared one bit wider so a duration shortened mid-step still ends at the next tick.
   assign stepDone   = tickWrap && (({1'b0, durCnt} + {{DUR_W{1'b0}}, 1'b1}) >= {1'b0, curDur});
   assign halfWrap   = (({1'b0, halfCnt} + {{HALF_W{1'b0}}, 1'b1}) >= {1'b0, curHalf});
   assign emptyEntry = (curDur == '0) && (tickCnt == '0) && (durCnt == '0);
   assign seqEnd     = lastStep || (nextDur == '0);

   always_comb begin
      stateNxt = state;
      tickNxt  = '0;
      durNxt   = '0;
      halfNxt  = '0;
      stepNxt  = '0;
      soundNxt = 1'b0;
      doneNxt  = 1'b0;
      case (state)
         IDLE: begin
            if (iSTART && !iSTOP) stateNxt = PLAY;
         end
         PLAY: begin
            if (iSTOP) begin
               stateNxt = IDLE;
            end else if (emptyEntry) begin
               stateNxt = IDLE;
               doneNxt  = 1'b1;
            end else if (stepDone) begin
               if (seqEnd) begin
`ifdef TONE_SEQUENCER_LOOP_EN
                  stepNxt = '0;
`else
                  stateNxt = IDLE;
                  doneNxt  = 1'b1;
`endif
               end else begin
                  stepNxt = stepR + ADDR_W'(1);
               end
            end else begin
               stepNxt = stepR;
               tickNxt = tickWrap ? '0 : tickCnt + TICK_W'(1);
               durNxt  = tickWrap ? durCnt + DUR_W'(1) : durCnt;
               if (curHalf != '0) begin
                  if (halfWrap) begin
                     soundNxt = ~sound;
                  end else begin
                     halfNxt  = halfCnt + HALF_W'(1);
                     soundNxt = sound;
                  end
               end
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state   <= IDLE;
         tickCnt <= '0;
         durCnt  <= '0;
         halfCnt <= '0;
         stepR   <= '0;
         sound   <= 1'b0;
         done    <= 1'b0;
         for (int unsigned i = 0; i < STEPS; i++) begin
            durTab[i]  <= '0;
            halfTab[i] <= '0;
         end
      end else begin
         state   <= stateNxt;
         tickCnt <= tickNxt;
         durCnt  <= durNxt;
         halfCnt <= halfNxt;
         stepR   <= stepNxt;
         sound   <= soundNxt;
         done    <= doneNxt;
         if (iWE) begin
            durTab[iWADDR]  <= iWDUR;
            halfTab[iWADDR] <= iWHALF;
         end
      end
   end

   assign oSOUND = sound;
   assign oBUSY  = (state == PLAY);
   assign oSTEP  = stepR;
   assign oDONE  = done;
endmodule

// File: tb/tb_tone_sequencer.sv
// Randomised scoreboard bench for tone_sequencer: a per-edge reference model pushes
// expected outputs; an independent monitor pops and compares on the falling edge.
module tb_tone_sequencer;
   localparam int ADDR_W = 3;
   localparam int DUR_W  = 4;
   localparam int HALF_W = 21;
   localparam int TD     = 10;
   localparam int STEPS  = 8;
`ifdef TONE_SEQUENCER_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic              iCLK = 1'b0;
   logic              iRST, iSTART, iSTOP, iWE;
   logic [ADDR_W-1:0] iWADDR;
   logic [DUR_W-1:0]  iWDUR;
   logic [HALF_W-1:0] iWHALF;
   logic              oSOUND, oBUSY, oDONE;
   logic [ADDR_W-1:0] oSTEP;

   tone_sequencer #(
      .ADDR_W(ADDR_W), .DUR_W(DUR_W), .HALF_W(HALF_W), .TICK_DIV(TD), .TICK_W(4)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP), .iWE(iWE),
      .iWADDR(iWADDR), .iWDUR(iWDUR), .iWHALF(iWHALF),
      .oSOUND(oSOUND), .oBUSY(oBUSY), .oSTEP(oSTEP), .oDONE(oDONE)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      bit snd;
      bit busy;
      int step;
      bit done;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: elapsed cycles within the current step and cycles since last toggle.
   int mdur[STEPS];
   int mhalf[STEPS];
   bit playing, msnd, mdone;
   int mstep, elapsed, since;

   task automatic idleModel();
      playing = 0; msnd = 0; mstep = 0; elapsed = 0; since = 0;
   endtask

   task automatic newStep(input int s);
      mstep = s; elapsed = 0; since = 0; msnd = 0;
   endtask

   task automatic modelEdge();
      int d, h;
      exp_t e;
      bit finished;
      if (iRST) begin
         idleModel();
         mdone = 0;
         for (int i = 0; i < STEPS; i++) begin
            mdur[i] = 0;
            mhalf[i] = 0;
         end
      end else begin
         mdone = 0;
         d = mdur[mstep];
         h = mhalf[mstep];
         if (iSTOP) begin
            idleModel();
         end else if (!playing) begin
            if (iSTART) begin
               playing = 1;
               newStep(0);
            end
         end else if (elapsed == 0 && d == 0) begin
            idleModel();
            mdone = 1;
         end else if ((elapsed + 1) % TD == 0 && (elapsed + 1) / TD >= d) begin
            finished = (mstep == STEPS - 1) || (mdur[mstep + 1] == 0);
            if (!finished) newStep(mstep + 1);
            else if (LOOP) newStep(0);
            else begin
               idleModel();
               mdone = 1;
            end
         end else begin
            elapsed++;
            if (h == 0) begin
               msnd = 0; since = 0;
            end else if (since + 1 >= h) begin
               msnd = !msnd; since = 0;
            end else begin
               since++;
            end
         end
         if (iWE) begin
            mdur[iWADDR]  = int'(iWDUR);
            mhalf[iWADDR] = int'(iWHALF);
         end
      end
      e.snd = msnd; e.busy = playing; e.step = mstep; e.done = mdone;
      expQ.push_back(e);
   endtask

   // One clock: the edge samples the inputs currently driven, then the model follows it.
   task automatic cyc();
      @(posedge iCLK);
      #1;
      modelEdge();
   endtask

   task automatic wr(input int a, input int d, input int h);
      iWE = 1; iWADDR = ADDR_W'(a); iWDUR = DUR_W'(d); iWHALF = HALF_W'(h);
      cyc();
      iWE = 0;
   endtask

   task automatic pulseStart();
      iSTART = 1;
      cyc();
      iSTART = 0;
   endtask

   function automatic void check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge iCLK);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("oSOUND", int'(oSOUND), int'(e.snd));
            check("oBUSY",  int'(oBUSY),  int'(e.busy));
            check("oSTEP",  int'(oSTEP),  e.step);
            check("oDONE",  int'(oDONE),  int'(e.done));
         end
      end
   end

   initial begin : stim
      iRST = 1; iSTART = 0; iSTOP = 0; iWE = 0; iWADDR = '0; iWDUR = '0; iWHALF = '0;
      playing = 0; msnd = 0; mdone = 0; mstep = 0; elapsed = 0; since = 0;
      cyc(); cyc();
      iRST = 0;

      // Two-tick tone then end marker; then same with half-period rewritten mid-step.
      wr(0, 2, 3); wr(1, 0, 0);
      pulseStart();
      repeat (25) cyc();
      pulseStart();
      repeat (4) cyc();
      wr(0, 2, 5);
      repeat (25) cyc();

      // Rest step, tone step, end marker; reset mid-play, then restart on an empty table.
      wr(0, 1, 0); wr(1, 1, 2); wr(2, 0, 0);
      pulseStart();
      repeat (12) cyc();
      iRST = 1; cyc(); iRST = 0;
      pulseStart();
      repeat (5) cyc();

      // Abort mid-play, and simultaneous start/stop while idle.
      wr(0, 2, 3); wr(1, 0, 0);
      pulseStart();
      repeat (7) cyc();
      iSTOP = 1; cyc(); iSTOP = 0;
      repeat (3) cyc();
      iSTART = 1; iSTOP = 1; cyc(); iSTART = 0; iSTOP = 0;
      repeat (3) cyc();

      // Full-length table to exercise the last-step boundary.
      for (int i = 0; i < STEPS; i++) wr(i, 1, i);
      pulseStart();
      repeat (90) cyc();

      for (int n = 0; n < 4000; n++) begin
         iRST   = ($urandom_range(0, 499) == 0);
         iSTOP  = ($urandom_range(0, 149) == 0);
         iSTART = ($urandom_range(0, 19) == 0);
         iWE    = ($urandom_range(0, 7) == 0);
         iWADDR = ADDR_W'($urandom_range(0, STEPS - 1));
         iWDUR  = ($urandom_range(0, 4) == 0) ? '0 : DUR_W'($urandom_range(1, 3));
         iWHALF = HALF_W'($urandom_range(0, 6));
         cyc();
      end
      iRST = 0; iSTOP = 0; iSTART = 0; iWE = 0;
      cyc();
      #10;
      check("drain", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
